uart_alu_ctrl: RTL and testbench

Sequencer between the UART RX/TX byte interfaces and the combinational ALU. It collects three bytes (operand A, operand B, opcode), checks the opcode, and strobes the ALU valid for one cycle. It then returns the result byte, or an error code, through UART TX. It sits between uart_rx/uart_tx and alu in the top level and is the only driver of the ALU inputs.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/uart_alu_ctrl_if.sv | 30 +++
 rtl/inter_byte_timer.sv | 29 ++
 rtl/uart_alu_ctrl.sv | 97 +++++++++
 tb/tb_uart_alu_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Definitions shared by the UART/ALU sequencer and the ALU: opcodes, state
// encoding and the error byte.
package alu_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_OP_DEF   = 6;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;

    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_ERR     = 3'd4;
    localparam logic [2:0] ST_SEND    = 3'd5;
    localparam logic [2:0] ST_WAIT_TX = 3'd6;

    typedef enum logic [2:0] {
        WAIT_A  = ST_WAIT_A,
        WAIT_B  = ST_WAIT_B,
        WAIT_OP = ST_WAIT_OP,
        EXEC    = ST_EXEC,
        ERR     = ST_ERR,
        SEND    = ST_SEND,
        WAIT_TX = ST_WAIT_TX
    } state_t;

    localparam logic [7:0] ERR_CODE_DEF = 8'hEE;

    function automatic logic is_valid_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Byte-level bus between the sequencer and its UART RX/TX and ALU neighbours.
interface uart_alu_ctrl_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_tx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_alu_datoA;
    logic [NB_DATA-1:0] o_alu_datoB;
    logic [NB_OP-1:0]   o_alu_op;
    logic               o_alu_valid;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_error;

    modport master (
        input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        output o_alu_datoA, o_alu_datoB, o_alu_op, o_alu_valid,
        output o_tx_data, o_tx_start, o_busy, o_error
    );

    modport slave (
        output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        input  o_alu_datoA, o_alu_datoB, o_alu_op, o_alu_valid,
        input  o_tx_data, o_tx_start, o_busy, o_error
    );
endinterface

// File: rtl/inter_byte_timer.sv
// Counts idle cycles between bytes of a frame; expired flags the terminal
// count for one cycle and the counter restarts from zero.
module inter_byte_timer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int NB_CNT = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [NB_CNT-1:0] TERM_CNT = NB_CNT'(TIMEOUT_CYC - 1);

    logic [NB_CNT-1:0] cnt;

    // A byte arriving on the terminal cycle clears the timer, so it wins.
    assign expired = enable & ~clear & (cnt == TERM_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || expired) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects operand A, operand B and opcode from UART RX, strobes the ALU,
// and returns the result (or an error byte) through UART TX.
module uart_alu_ctrl
    import alu_pkg::*;
#(
    parameter int                 NB_DATA     = NB_DATA_DEF,
    parameter int                 NB_OP       = NB_OP_DEF,
    parameter int                 TIMEOUT_CYC = 100000,
    parameter logic [NB_DATA-1:0] ERR_CODE    = NB_DATA'(ERR_CODE_DEF)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    uart_alu_ctrl_if.master bus
);
    // state   | meaning
    // WAIT_A  | idle, waiting for operand A
    // WAIT_B  | waiting for operand B (timed)
    // WAIT_OP | waiting for opcode (timed)
    // EXEC    | ALU strobed, result captured for TX
    // ERR     | invalid opcode, error byte captured for TX
    // SEND    | TX start strobe
    // WAIT_TX | waiting for TX to finish

    state_t state, state_next;
    logic   timed;
    logic   expired;
    logic   op_ok;

    assign timed = (state == WAIT_B) || (state == WAIT_OP);
    assign op_ok = is_valid_op(bus.i_rx_data[NB_OP-1:0]);

    inter_byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clear   (~timed | bus.i_rx_done),
        .enable  (timed),
        .expired (expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_A: begin
                if (bus.i_rx_done) state_next = WAIT_B;
            end
            WAIT_B: begin
                if (bus.i_rx_done)  state_next = WAIT_OP;
                else if (expired)   state_next = WAIT_A;
            end
            WAIT_OP: begin
                if (bus.i_rx_done)  state_next = op_ok ? EXEC : ERR;
                else if (expired)   state_next = WAIT_A;
            end
            EXEC:    state_next = SEND;
            ERR:     state_next = SEND;
            SEND:    state_next = WAIT_TX;
            WAIT_TX: begin
                if (bus.i_tx_done) state_next = WAIT_A;
            end
            default: state_next = WAIT_A;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_alu_datoA <= '0;
            bus.o_alu_datoB <= '0;
            bus.o_alu_op    <= '0;
            bus.o_alu_valid <= 1'b0;
            bus.o_tx_data   <= '0;
            bus.o_tx_start  <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_error     <= 1'b0;
        end else begin
            if (bus.i_rx_done && state == WAIT_A)  bus.o_alu_datoA <= bus.i_rx_data;
            if (bus.i_rx_done && state == WAIT_B)  bus.o_alu_datoB <= bus.i_rx_data;
            if (bus.i_rx_done && state == WAIT_OP) bus.o_alu_op    <= bus.i_rx_data[NB_OP-1:0];
            if (state == EXEC) bus.o_tx_data <= bus.i_alu_result;
            if (state == ERR)  bus.o_tx_data <= ERR_CODE;
            bus.o_alu_valid <= (state_next == EXEC);
            bus.o_tx_start  <= (state_next == SEND);
            bus.o_busy      <= (state_next != WAIT_A);
            bus.o_error     <= (state_next == ERR) || expired;
        end
    end
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl: stimulus pushes expected TX bytes,
// a monitor pops and compares on every o_tx_start.
module tb_uart_alu_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uart_alu_ctrl_if #(.NB_DATA(8), .NB_OP(6)) bus ();

    uart_alu_ctrl #(
        .NB_DATA     (8),
        .NB_OP       (6),
        .TIMEOUT_CYC (16),
        .ERR_CODE    (8'hEE)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.master)
    );

    // Behavioural ALU standing in for the real one.
    logic [7:0] alu_r;
    always_comb begin
        alu_r = 8'h00;
        case (bus.o_alu_op)
            OP_ADD: alu_r = bus.o_alu_datoA + bus.o_alu_datoB;
            OP_SUB: alu_r = bus.o_alu_datoA - bus.o_alu_datoB;
            OP_AND: alu_r = bus.o_alu_datoA & bus.o_alu_datoB;
            OP_OR:  alu_r = bus.o_alu_datoA | bus.o_alu_datoB;
            OP_XOR: alu_r = bus.o_alu_datoA ^ bus.o_alu_datoB;
            OP_NOR: alu_r = ~(bus.o_alu_datoA | bus.o_alu_datoB);
            OP_SRA: alu_r = $signed(bus.o_alu_datoA) >>> bus.o_alu_datoB;
            OP_SRL: alu_r = bus.o_alu_datoA >> bus.o_alu_datoB;
            default: alu_r = 8'h00;
        endcase
    end
    assign bus.i_alu_result = alu_r;

    typedef struct {
        logic [7:0] data;
        int         valid;
        int         err;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: counts strobes between TX starts and checks each TX byte.
    int valid_cnt = 0;
    int err_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            valid_cnt = 0;
            err_cnt = 0;
        end else begin
            if (bus.o_alu_valid) valid_cnt++;
            if (bus.o_error)     err_cnt++;
            if (bus.o_tx_start) begin
                if (sb.size() == 0) begin
                    chk("unexpected_tx_start", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("tx_data", int'(bus.o_tx_data), int'(e.data));
                    chk("alu_valid_count", valid_cnt, e.valid);
                    chk("error_count", err_cnt, e.err);
                end
                valid_cnt = 0;
                err_cnt = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_datoA"}, int'(bus.o_alu_datoA), 0);
        chk({name, "_datoB"}, int'(bus.o_alu_datoB), 0);
        chk({name, "_op"},    int'(bus.o_alu_op), 0);
        chk({name, "_valid"}, int'(bus.o_alu_valid), 0);
        chk({name, "_txdata"}, int'(bus.o_tx_data), 0);
        chk({name, "_txstart"}, int'(bus.o_tx_start), 0);
        chk({name, "_busy"},  int'(bus.o_busy), 0);
        chk({name, "_error"}, int'(bus.o_error), 0);
    endtask

    // Full frame with latency checks; gap idles before operand B.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] exp_data,
                             input int exp_valid, input int exp_err,
                             input int gap, input bit extra);
        sb.push_back('{exp_data, exp_valid, exp_err});
        send_byte(a);
        repeat (gap) @(negedge clk);
        send_byte(b);
        send_byte(op);
        chk("alu_valid_lat", int'(bus.o_alu_valid), exp_valid);
        chk("error_lat", int'(bus.o_error), 1 - exp_valid);
        chk("tx_start_early", int'(bus.o_tx_start), 0);
        @(negedge clk);
        chk("tx_start_lat", int'(bus.o_tx_start), 1);
        @(negedge clk);
        if (extra) send_byte(8'hAA);
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        chk("busy_after_done", int'(bus.o_busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.i_rx_data = 8'h00;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(8'h05, 8'h03, 8'h20, 8'h08, 1, 0, 0, 0);
        run_frame(8'h03, 8'h05, 8'h22, 8'hFE, 1, 0, 0, 0);
        run_frame(8'h80, 8'h01, 8'h03, 8'hC0, 1, 0, 0, 0);
        run_frame(8'h80, 8'h01, 8'h02, 8'h40, 1, 0, 0, 0);
        run_frame(8'h0F, 8'hF0, 8'h3F, 8'hEE, 0, 1, 0, 0);
        chk("err_keep_datoA", int'(bus.o_alu_datoA), 8'h0F);
        chk("err_keep_datoB", int'(bus.o_alu_datoB), 8'hF0);

        // Timeout after operand A: error 16 cycles after the byte.
        send_byte(8'h05);
        n = 0;
        while (!bus.o_error && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_busy", int'(bus.o_busy), 0);
        chk("timeout_keep_datoA", int'(bus.o_alu_datoA), 8'h05);
        @(negedge clk);
        run_frame(8'h01, 8'h01, 8'h20, 8'h02, 1, 1, 0, 0);

        // Byte on the terminal-count cycle is accepted.
        run_frame(8'h05, 8'h03, 8'h20, 8'h08, 1, 0, 15, 0);

        run_frame(8'h09, 8'h04, 8'h25, 8'h0D, 1, 0, 0, 1);
        run_frame(8'h02, 8'h02, 8'h24, 8'h02, 1, 0, 0, 0);
        chk("datoA_after_extra", int'(bus.o_alu_datoA), 8'h02);

        // Reset in WAIT_B.
        send_byte(8'h09);
        chk("busy_wait_b", int'(bus.o_busy), 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_wait_b");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in WAIT_TX.
        sb.push_back('{8'h03, 1, 0});
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h20);
        @(negedge clk);
        @(negedge clk);
        chk("busy_wait_tx", int'(bus.o_busy), 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_wait_tx");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_rst_busy", int'(bus.o_busy), 0);

        run_frame(8'h07, 8'h01, 8'h26, 8'h06, 1, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
